// File: rtl/serializer_arbiter_if.sv
// Bundle of the requester-side and serializer-side signals of serializer_arbiter.
// The master modport is the arbiter's view: it drives the serializer inputs and the acks.
// The slave modport is the environment's view: the requesters plus the serializer itself.
interface serializer_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 16,
  parameter int MOD_W = $clog2(WIDTH) + 1
);
  logic [N_REQ-1:0]       req_val_i;
  logic [N_REQ*WIDTH-1:0] req_data_i;
  logic [N_REQ*MOD_W-1:0] req_mod_i;
  logic [N_REQ-1:0]       req_ack_o;
  logic [N_REQ-1:0]       grant_o;
  logic [WIDTH-1:0]       ser_data_o;
  logic [MOD_W-1:0]       ser_mod_o;
  logic                   ser_val_o;
  logic                   ser_busy_i;
  logic                   drop_o;

  modport master (
    input  req_val_i, req_data_i, req_mod_i, ser_busy_i,
    output req_ack_o, grant_o, ser_data_o, ser_mod_o, ser_val_o, drop_o
  );

  modport slave (
    output req_val_i, req_data_i, req_mod_i, ser_busy_i,
    input  req_ack_o, grant_o, ser_data_o, ser_mod_o, ser_val_o, drop_o
  );
endinterface

// File: rtl/serializer_arbiter.sv
// serializer_arbiter: shares one serializer among N_REQ requesters with round-robin
// arbitration. One word is launched at a time with a single-cycle ser_val_o pulse; the
// arbiter then follows the serializer's busy flag until the word has been shifted out,
// or drops the word if busy never rises within BUSY_TIMEOUT cycles.
// The interface instance must be built with the same N_REQ/WIDTH and the default MOD_W.
module serializer_arbiter #(
  parameter int N_REQ        = 4,
  parameter int WIDTH        = 16,
  parameter int BUSY_TIMEOUT = 4
) (
  input  logic                 clk_i,
  input  logic                 srst_i,
  serializer_arbiter_if.master bus
);

  localparam int MOD_W = $clog2(WIDTH) + 1;
  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CNT_W = (BUSY_TIMEOUT > 1) ? $clog2(BUSY_TIMEOUT + 1) : 1;

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] LAUNCH    = 2'd1;
  localparam logic [1:0] WAIT_BUSY = 2'd2;
  localparam logic [1:0] WAIT_DONE = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [IDX_W-1:0] last_winner_q, last_winner_d;
  logic [IDX_W-1:0] winner_q, winner_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic [N_REQ-1:0] ack_q, ack_d;
  logic             val_q, val_d;
  logic             drop_q, drop_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [MOD_W-1:0] mod_q, mod_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             pick_found;
  logic [IDX_W-1:0] pick_idx;
  logic [IDX_W:0]   cand;
  logic [WIDTH-1:0] pick_data;
  logic [MOD_W-1:0] pick_mod;

  // Round-robin search: start one past the last winner and wrap at N_REQ, so the most
  // recently served requester always ends up with the lowest priority.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int i = 1; i <= N_REQ; i++) begin
      cand = {1'b0, last_winner_q} + (IDX_W+1)'(i);
      if (cand >= (IDX_W+1)'(N_REQ)) begin
        cand = cand - (IDX_W+1)'(N_REQ);
      end
      if (!pick_found && bus.req_val_i[cand[IDX_W-1:0]]) begin
        pick_found = 1'b1;
        pick_idx   = cand[IDX_W-1:0];
      end
    end
  end

  // Select the winning requester's word and valid-bit count from the flat buses.
  always_comb begin
    pick_data = '0;
    pick_mod  = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (pick_idx == IDX_W'(k)) begin
        pick_data = bus.req_data_i[k*WIDTH +: WIDTH];
        pick_mod  = bus.req_mod_i[k*MOD_W +: MOD_W];
      end
    end
  end

  // Transfer FSM: the val/ack pulses are set on entry to LAUNCH so they appear exactly
  // during the LAUNCH cycle; data/mod are captured at grant time and held until the next grant.
  always_comb begin
    state_d       = state_q;
    last_winner_d = last_winner_q;
    winner_d      = winner_q;
    grant_d       = grant_q;
    ack_d         = '0;
    val_d         = 1'b0;
    drop_d        = 1'b0;
    data_d        = data_q;
    mod_d         = mod_q;
    cnt_d         = cnt_q;
    case (state_q)
      IDLE: begin
        if (pick_found && !bus.ser_busy_i) begin
          winner_d          = pick_idx;
          grant_d           = '0;
          grant_d[pick_idx] = 1'b1;
          ack_d             = '0;
          ack_d[pick_idx]   = 1'b1;
          val_d             = 1'b1;
          data_d            = pick_data;
          mod_d             = pick_mod;
          state_d           = LAUNCH;
        end
      end
      LAUNCH: begin
        last_winner_d = winner_q;
        cnt_d         = '0;
        state_d       = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (bus.ser_busy_i) begin
          state_d = WAIT_DONE;
        end else if (cnt_q == CNT_W'(BUSY_TIMEOUT - 1)) begin
          drop_d  = 1'b1;
          grant_d = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      WAIT_DONE: begin
        if (!bus.ser_busy_i) begin
          grant_d = '0;
          state_d = IDLE;
        end
      end
      default: begin
        grant_d = '0;
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; reset aborts any transfer and makes requester 0 first in line.
  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      state_q       <= IDLE;
      last_winner_q <= IDX_W'(N_REQ - 1);
      winner_q      <= '0;
      grant_q       <= '0;
      ack_q         <= '0;
      val_q         <= 1'b0;
      drop_q        <= 1'b0;
      data_q        <= '0;
      mod_q         <= '0;
      cnt_q         <= '0;
    end else begin
      state_q       <= state_d;
      last_winner_q <= last_winner_d;
      winner_q      <= winner_d;
      grant_q       <= grant_d;
      ack_q         <= ack_d;
      val_q         <= val_d;
      drop_q        <= drop_d;
      data_q        <= data_d;
      mod_q         <= mod_d;
      cnt_q         <= cnt_d;
    end
  end

  assign bus.req_ack_o  = ack_q;
  assign bus.grant_o    = grant_q;
  assign bus.ser_data_o = data_q;
  assign bus.ser_mod_o  = mod_q;
  assign bus.ser_val_o  = val_q;
  assign bus.drop_o     = drop_q;

endmodule

// File: tb/tb_serializer_arbiter.sv
// Testbench for serializer_arbiter: a serializer model drives busy, expected launches are
// queued when requests are driven and compared when ser_val_o pulses.
module tb_serializer_arbiter;

  localparam int N_REQ        = 4;
  localparam int WIDTH        = 16;
  localparam int MOD_W        = 5;
  localparam int BUSY_TIMEOUT = 4;

  typedef struct {
    int               idx;
    logic [WIDTH-1:0] data;
    logic [MOD_W-1:0] mod;
  } exp_t;

  logic clk  = 1'b0;
  logic srst = 1'b1;

  int   checks = 0;
  int   passes = 0;
  exp_t exp_q[$];

  bit force_busy = 1'b0;
  bit ignore_val = 1'b0;
  int busy_len   = 3;
  bit busy_model = 1'b0;
  int busy_rem   = 0;
  bit val_seen   = 1'b0;

  serializer_arbiter_if #(.N_REQ(N_REQ), .WIDTH(WIDTH), .MOD_W(MOD_W)) bus ();

  serializer_arbiter #(
    .N_REQ(N_REQ), .WIDTH(WIDTH), .BUSY_TIMEOUT(BUSY_TIMEOUT)
  ) dut (
    .clk_i(clk), .srst_i(srst), .bus(bus.master)
  );

  always #5 clk = ~clk;

  // Serializer model: busy rises the cycle after a val pulse and stays up for busy_len cycles.
  always @(negedge clk) val_seen = bus.ser_val_o;

  always @(posedge clk) begin
    #1;
    if (val_seen && !ignore_val) begin
      busy_model = 1'b1;
      busy_rem   = busy_len;
    end else if (busy_rem > 0) begin
      busy_rem = busy_rem - 1;
      if (busy_rem == 0) busy_model = 1'b0;
    end
  end

  assign bus.ser_busy_i = force_busy | busy_model;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [N_REQ-1:0] onehot(input int k);
    logic [N_REQ-1:0] v;
    v    = '0;
    v[k] = 1'b1;
    return v;
  endfunction

  function automatic logic [WIDTH-1:0] word_of(input int k);
    return 16'h3C00 ^ (16'h1111 * 16'(k));
  endfunction

  task automatic set_req(input int k, input logic [WIDTH-1:0] d, input logic [MOD_W-1:0] m);
    bus.req_data_i[k*WIDTH +: WIDTH] = d;
    bus.req_mod_i[k*MOD_W +: MOD_W]  = m;
  endtask

  task automatic wait_val(input int limit, output bit seen, output int waited);
    seen   = 1'b0;
    waited = 0;
    while (!seen && waited < limit) begin
      @(negedge clk);
      waited++;
      if (bus.ser_val_o === 1'b1) seen = 1'b1;
    end
  endtask

  task automatic wait_idle(input int limit, output bit ok);
    int n;
    n  = 0;
    ok = 1'b0;
    while (!ok && n < limit) begin
      @(negedge clk);
      n++;
      if (bus.grant_o === '0 && bus.ser_busy_i === 1'b0) ok = 1'b1;
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    srst = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (bus.grant_o !== '0) $display("[TB] FAIL reset_grant: got %b expected 0", bus.grant_o); else passes++;
    checks++; if (bus.req_ack_o !== '0) $display("[TB] FAIL reset_ack: got %b expected 0", bus.req_ack_o); else passes++;
    checks++; if (bus.ser_val_o !== 1'b0) $display("[TB] FAIL reset_val: got %b expected 0", bus.ser_val_o); else passes++;
    checks++; if (bus.drop_o !== 1'b0) $display("[TB] FAIL reset_drop: got %b expected 0", bus.drop_o); else passes++;
    checks++; if (bus.ser_data_o !== '0) $display("[TB] FAIL reset_data: got %h expected 0", bus.ser_data_o); else passes++;
    checks++; if (bus.ser_mod_o !== '0) $display("[TB] FAIL reset_mod: got %h expected 0", bus.ser_mod_o); else passes++;
    srst = 1'b0;
  endtask

  task automatic test_single();
    bit   seen, ok, extra;
    int   waited, held;
    exp_t e;
    busy_len = 4;
    set_req(2, 16'hC501, 5'd4);
    exp_q.push_back('{2, 16'hC501, 5'd4});
    bus.req_val_i = 4'b0100;
    wait_val(10, seen, waited);
    checks++; if (!seen || waited != 1) $display("[TB] FAIL single_latency: got seen=%0d after %0d expected 1 after 1", seen, waited); else passes++;
    e = exp_q.pop_front();
    checks++; if (bus.req_ack_o !== onehot(e.idx)) $display("[TB] FAIL single_ack: got %b expected %b", bus.req_ack_o, onehot(e.idx)); else passes++;
    checks++; if (bus.grant_o !== onehot(e.idx)) $display("[TB] FAIL single_grant: got %b expected %b", bus.grant_o, onehot(e.idx)); else passes++;
    checks++; if (bus.ser_data_o !== e.data) $display("[TB] FAIL single_data: got %h expected %h", bus.ser_data_o, e.data); else passes++;
    checks++; if (bus.ser_mod_o !== e.mod) $display("[TB] FAIL single_mod: got %h expected %h", bus.ser_mod_o, e.mod); else passes++;
    bus.req_val_i = '0;
    held  = 0;
    extra = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (bus.grant_o === '0) break;
      if (bus.grant_o !== 4'b0100) extra = 1'b1;
      if (bus.ser_val_o !== 1'b0 || bus.req_ack_o !== '0 || bus.drop_o !== 1'b0) extra = 1'b1;
      held++;
    end
    checks++; if (held != busy_len + 1) $display("[TB] FAIL single_hold: got %0d cycles expected %0d", held, busy_len + 1); else passes++;
    checks++; if (extra) $display("[TB] FAIL single_quiet: got stray pulse or grant expected none"); else passes++;
    wait_idle(30, ok);
    checks++; if (!ok) $display("[TB] FAIL single_idle: got busy expected idle"); else passes++;
  endtask

  task automatic test_round_robin();
    bit   seen, ok;
    int   waited;
    exp_t e;
    int   order[5] = '{0, 1, 2, 3, 0};
    srst = 1'b1;
    @(negedge clk);
    srst     = 1'b0;
    busy_len = 2;
    for (int k = 0; k < N_REQ; k++) set_req(k, word_of(k), MOD_W'(k + 9));
    for (int n = 0; n < 5; n++) exp_q.push_back('{order[n], word_of(order[n]), MOD_W'(order[n] + 9)});
    bus.req_val_i = 4'b1111;
    for (int n = 0; n < 5; n++) begin
      wait_val(20, seen, waited);
      checks++;
      if (!seen || waited != ((n == 0) ? 1 : busy_len + 3))
        $display("[TB] FAIL rr_spacing_%0d: got seen=%0d after %0d expected 1 after %0d", n, seen, waited, (n == 0) ? 1 : busy_len + 3);
      else passes++;
      e = exp_q.pop_front();
      checks++; if (bus.req_ack_o !== onehot(e.idx)) $display("[TB] FAIL rr_ack_%0d: got %b expected %b", n, bus.req_ack_o, onehot(e.idx)); else passes++;
      checks++; if (bus.grant_o !== onehot(e.idx)) $display("[TB] FAIL rr_grant_%0d: got %b expected %b", n, bus.grant_o, onehot(e.idx)); else passes++;
      checks++; if (bus.ser_data_o !== e.data) $display("[TB] FAIL rr_data_%0d: got %h expected %h", n, bus.ser_data_o, e.data); else passes++;
    end
    bus.req_val_i = '0;
    wait_idle(30, ok);
    checks++; if (!ok) $display("[TB] FAIL rr_idle: got busy expected idle"); else passes++;
  endtask

  task automatic test_wrap();
    bit               seen, ok;
    int               waited, pos;
    exp_t             e;
    logic [N_REQ-1:0] masks [3];
    int               order[5] = '{1, 3, 1, 0, 1};
    int               cnt[3]   = '{1, 2, 2};
    masks[0] = 4'b0010;
    masks[1] = 4'b1010;
    masks[2] = 4'b0011;
    srst = 1'b1;
    @(negedge clk);
    srst     = 1'b0;
    busy_len = 1;
    pos      = 0;
    for (int p = 0; p < 3; p++) begin
      for (int n = 0; n < cnt[p]; n++)
        exp_q.push_back('{order[pos+n], word_of(order[pos+n]), MOD_W'(order[pos+n] + 9)});
      bus.req_val_i = masks[p];
      for (int n = 0; n < cnt[p]; n++) begin
        wait_val(20, seen, waited);
        checks++; if (!seen) $display("[TB] FAIL wrap_launch_%0d: got none expected launch", pos); else passes++;
        e = exp_q.pop_front();
        checks++; if (bus.req_ack_o !== onehot(e.idx)) $display("[TB] FAIL wrap_ack_%0d: got %b expected %b", pos, bus.req_ack_o, onehot(e.idx)); else passes++;
        checks++; if (bus.ser_mod_o !== e.mod) $display("[TB] FAIL wrap_mod_%0d: got %h expected %h", pos, bus.ser_mod_o, e.mod); else passes++;
        bus.req_val_i[e.idx] = 1'b0;
        pos++;
      end
      bus.req_val_i = '0;
      wait_idle(30, ok);
      checks++; if (!ok) $display("[TB] FAIL wrap_idle_%0d: got busy expected idle", p); else passes++;
    end
  endtask

  task automatic test_drop();
    bit   seen, ok, dropped;
    int   waited, k;
    exp_t e;
    ignore_val = 1'b1;
    set_req(0, 16'h5A5A, 5'd2);
    exp_q.push_back('{0, 16'h5A5A, 5'd2});
    bus.req_val_i = 4'b0001;
    wait_val(10, seen, waited);
    checks++; if (!seen) $display("[TB] FAIL drop_launch: got none expected launch"); else passes++;
    e = exp_q.pop_front();
    checks++; if (bus.req_ack_o !== onehot(e.idx)) $display("[TB] FAIL drop_ack: got %b expected %b", bus.req_ack_o, onehot(e.idx)); else passes++;
    checks++; if (bus.ser_mod_o !== e.mod) $display("[TB] FAIL drop_mod: got %h expected %h", bus.ser_mod_o, e.mod); else passes++;
    bus.req_val_i = '0;
    k       = 0;
    dropped = 1'b0;
    while (!dropped && k < 20) begin
      @(negedge clk);
      k++;
      if (bus.drop_o === 1'b1) dropped = 1'b1;
    end
    checks++; if (!dropped || k != BUSY_TIMEOUT + 1) $display("[TB] FAIL drop_timing: got seen=%0d after %0d expected 1 after %0d", dropped, k, BUSY_TIMEOUT + 1); else passes++;
    checks++; if (bus.grant_o !== '0) $display("[TB] FAIL drop_grant: got %b expected 0", bus.grant_o); else passes++;
    ignore_val = 1'b0;
    set_req(1, 16'h0F0F, 5'd7);
    exp_q.push_back('{1, 16'h0F0F, 5'd7});
    bus.req_val_i = 4'b0010;
    @(negedge clk);
    checks++; if (bus.drop_o !== 1'b0) $display("[TB] FAIL drop_pulse: got %b expected 0", bus.drop_o); else passes++;
    checks++; if (bus.ser_val_o !== 1'b1) $display("[TB] FAIL drop_next_val: got %b expected 1", bus.ser_val_o); else passes++;
    e = exp_q.pop_front();
    checks++; if (bus.req_ack_o !== onehot(e.idx)) $display("[TB] FAIL drop_next_ack: got %b expected %b", bus.req_ack_o, onehot(e.idx)); else passes++;
    checks++; if (bus.ser_data_o !== e.data) $display("[TB] FAIL drop_next_data: got %h expected %h", bus.ser_data_o, e.data); else passes++;
    bus.req_val_i = '0;
    wait_idle(30, ok);
    checks++; if (!ok) $display("[TB] FAIL drop_idle: got busy expected idle"); else passes++;
  endtask

  task automatic test_busy_block();
    bit   seen, ok, early;
    int   waited;
    exp_t e;
    force_busy = 1'b1;
    set_req(0, 16'hBEEF, 5'd9);
    exp_q.push_back('{0, 16'hBEEF, 5'd9});
    bus.req_val_i = 4'b0001;
    early = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (bus.ser_val_o !== 1'b0 || bus.req_ack_o !== '0 || bus.grant_o !== '0) early = 1'b1;
    end
    checks++; if (early) $display("[TB] FAIL block_no_launch: got launch expected none while busy"); else passes++;
    force_busy = 1'b0;
    wait_val(5, seen, waited);
    checks++; if (!seen || waited != 1) $display("[TB] FAIL block_release: got seen=%0d after %0d expected 1 after 1", seen, waited); else passes++;
    e = exp_q.pop_front();
    checks++; if (bus.ser_data_o !== e.data) $display("[TB] FAIL block_data: got %h expected %h", bus.ser_data_o, e.data); else passes++;
    bus.req_val_i = '0;
    wait_idle(30, ok);
    checks++; if (!ok) $display("[TB] FAIL block_idle: got busy expected idle"); else passes++;
  endtask

  task automatic test_reset_mid();
    bit   seen, ok;
    int   waited;
    exp_t e;
    busy_len = 8;
    set_req(2, 16'h7E81, 5'd6);
    exp_q.push_back('{2, 16'h7E81, 5'd6});
    exp_q.push_back('{2, 16'h7E81, 5'd6});
    bus.req_val_i = 4'b0100;
    wait_val(5, seen, waited);
    checks++; if (!seen) $display("[TB] FAIL mid_launch: got none expected launch"); else passes++;
    e = exp_q.pop_front();
    checks++; if (bus.req_ack_o !== onehot(e.idx)) $display("[TB] FAIL mid_ack: got %b expected %b", bus.req_ack_o, onehot(e.idx)); else passes++;
    repeat (3) @(negedge clk);
    checks++; if (bus.grant_o !== 4'b0100 || bus.ser_busy_i !== 1'b1) $display("[TB] FAIL mid_transfer: got grant=%b busy=%b expected 0100/1", bus.grant_o, bus.ser_busy_i); else passes++;
    srst = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.grant_o !== '0 || bus.req_ack_o !== '0 || bus.ser_val_o !== 1'b0 || bus.drop_o !== 1'b0 || bus.ser_data_o !== '0 || bus.ser_mod_o !== '0)
      $display("[TB] FAIL mid_reset_outputs: got grant=%b ack=%b val=%b drop=%b data=%h mod=%h expected all 0",
               bus.grant_o, bus.req_ack_o, bus.ser_val_o, bus.drop_o, bus.ser_data_o, bus.ser_mod_o);
    else passes++;
    srst = 1'b0;
    wait_val(20, seen, waited);
    checks++; if (!seen || waited != busy_len - 2) $display("[TB] FAIL mid_relaunch: got seen=%0d after %0d expected 1 after %0d", seen, waited, busy_len - 2); else passes++;
    e = exp_q.pop_front();
    checks++; if (bus.req_ack_o !== onehot(e.idx)) $display("[TB] FAIL mid_relaunch_ack: got %b expected %b", bus.req_ack_o, onehot(e.idx)); else passes++;
    checks++; if (bus.ser_data_o !== e.data) $display("[TB] FAIL mid_relaunch_data: got %h expected %h", bus.ser_data_o, e.data); else passes++;
    bus.req_val_i = '0;
    wait_idle(40, ok);
    checks++; if (!ok) $display("[TB] FAIL mid_idle: got busy expected idle"); else passes++;
  endtask

  initial begin
    bus.req_val_i  = '0;
    bus.req_data_i = '0;
    bus.req_mod_i  = '0;
    $display("[TB] starting serializer_arbiter tests");
    test_reset();
    @(negedge clk);
    test_single();
    test_round_robin();
    test_wrap();
    test_drop();
    test_busy_block();
    test_reset_mid();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
